bk_operand_sequencer: RTL and testbench

- Upstream feeder for the 6-bit Brent-Kung adder.
- Collects operand A, operand B and carry-in from a narrow valid/ready input stream and holds them stable on the adder inputs.
- Waits one settle cycle, then captures the adder's 8-bit result into a held output register and keeps it until acknowledged.
- Accumulate mode reuses the previous result's low bits as operand A, so chained additions need only one beat each.

---
 rtl/bk_operand_sequencer_pkg.sv | 18 +
 rtl/bk_operand_sequencer_sat_counter.sv | 23 ++
 rtl/bk_operand_sequencer.sv | 143 ++++++++++++++
 tb/tb_bk_operand_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_operand_sequencer_pkg.sv
// Shared definitions for the Brent-Kung adder operand sequencer.
//   - Default operand/result/counter widths, so the adder, the sequencer
//     and the top-level mux all agree.
//   - Sequencer state encoding.
package bk_operand_sequencer_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int SUM_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EVAL   = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

endpackage : bk_operand_sequencer_pkg

// File: rtl/bk_operand_sequencer_sat_counter.sv
// bk_sat_counter: CNT_W-bit saturating incrementer with synchronous enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   en    : increment on this edge (no effect once all-ones)
//   count : current count value
module bk_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : bk_sat_counter

// File: rtl/bk_operand_sequencer.sv
// bk_operand_sequencer: upstream feeder for the 6-bit Brent-Kung adder.
// Collects A, B and carry-in from a valid/ready beat stream, holds them on
// the adder inputs, waits one settle cycle, captures the result and holds it
// until acknowledged. Accumulate mode reuses the last result as operand A.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous soft clear (keeps res_data, op_count)
//   in_data/in_cin      : operand beat / carry-in (carry taken with B beat)
//   in_valid/in_ready   : beat handshake
//   acc_mode            : first beat in IDLE is operand B, A = previous result
//   op_a/op_b/op_cin    : registered adder operands
//   sum_in              : combinational adder result
//   res_data/res_valid  : held result, released by res_ack
//   busy                : sequencer not idle
//   op_count            : saturating count of completed operations
module bk_operand_sequencer
    import bk_operand_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_mode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    input  logic [SUM_W-1:0] sum_in,
    output logic [SUM_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [WIDTH-1:0] acc_reg;
    logic             acc_valid;
    logic             beat;
    logic             take_acc;
    logic             count_en;

    assign beat     = in_valid && in_ready;
    // A first beat in accumulate mode is operand B; A comes from acc_reg.
    assign take_acc = (state == IDLE) && acc_mode && acc_valid;
    // clear wins over EVAL, so a cleared evaluation does not count.
    assign count_en = (state == EVAL) && !clear;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (beat) state_nxt = take_acc ? EVAL : WAIT_B;
            WAIT_B:  if (beat) state_nxt = EVAL;
            EVAL:    state_nxt = HOLD;
            HOLD:    if (res_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only; no path from in_valid to in_ready.
    always_comb begin
        in_ready = (state == IDLE) || (state == WAIT_B);
        busy     = (state != IDLE);
    end

    // Operand, result and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            acc_reg   <= '0;
            acc_valid <= 1'b0;
        end else if (clear) begin
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            res_valid <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        if (take_acc) begin
                            op_a   <= acc_reg;
                            op_b   <= in_data;
                            op_cin <= in_cin;
                        end else begin
                            op_a <= in_data;
                        end
                    end
                end
                WAIT_B: begin
                    if (beat) begin
                        op_b   <= in_data;
                        op_cin <= in_cin;
                    end
                end
                EVAL: begin
                    res_data  <= sum_in;
                    res_valid <= 1'b1;
                    // Carry-out and upper bits drop: chaining wraps mod 2^WIDTH.
                    acc_reg   <= sum_in[WIDTH-1:0];
                    acc_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ack) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    bk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_op_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (count_en),
        .count (op_count)
    );

endmodule : bk_operand_sequencer

// File: tb/tb_bk_operand_sequencer.sv
// Self-checking bench for bk_operand_sequencer: directed scenarios plus
// randomized operations, results checked by a scoreboard-fed monitor.
module tb_bk_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [5:0] in_data;
    logic       in_cin;
    logic       in_valid;
    logic       in_ready;
    logic       acc_mode;
    logic [5:0] op_a;
    logic [5:0] op_b;
    logic       op_cin;
    logic [7:0] sum_in;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ack;
    logic       busy;
    logic [7:0] op_count;

    bk_operand_sequencer #(
        .WIDTH (6),
        .SUM_W (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_mode  (acc_mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .sum_in    (sum_in),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Adder model: 7-bit sum zero-extended to 8 bits.
    assign sum_in = {2'b00, op_a} + {2'b00, op_b} + {7'd0, op_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: last result (mod 64), whether it is usable,
    // and the saturating count of completed operations.
    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        int         edge_no;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] m_acc    = '0;
    bit         m_acc_ok = 1'b0;
    int         m_cnt    = 0;

    task automatic model_reset();
        m_acc    = '0;
        m_acc_ok = 1'b0;
        m_cnt    = 0;
        sb.delete();
    endtask

    // b_edge_pre: edge count at the negedge before the edge accepting B.
    task automatic push_exp(input logic [5:0] a, input logic [5:0] b, input bit cin,
                            input int b_edge_pre);
        int   s;
        exp_t e;
        s = int'(a) + int'(b) + int'(cin);
        if (m_cnt < 255) m_cnt++;
        e.data    = 8'(s);
        e.cnt     = 8'(m_cnt);
        e.edge_no = b_edge_pre + 2;
        sb.push_back(e);
        m_acc    = 6'(s % 64);
        m_acc_ok = 1'b1;
    endtask

    // Monitor: each new result is popped and compared, including latency.
    bit prev_rv = 1'b0;
    always @(negedge clk) begin
        if (res_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%0h expected no result", res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("op_count", 32'(op_count), 32'(e.cnt));
                chk("latency_edge", edge_cnt, e.edge_no);
            end
        end
        prev_rv = res_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [5:0] d, input bit cin, input bit acc, output int n);
        int waited;
        in_data  = d;
        in_cin   = cin;
        acc_mode = acc;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("beat_timeout", 32'(in_ready), 32'd1);
        end
        n = edge_cnt;
        @(negedge clk);
        in_valid = 1'b0;
        acc_mode = bit'($urandom_range(0, 1));
        in_cin   = bit'($urandom_range(0, 1));
    endtask

    task automatic do_op(input bit acc, input logic [5:0] a, input logic [5:0] b, input bit cin);
        int n;
        if (acc && m_acc_ok) begin
            send_beat(b, cin, 1'b1, n);
            push_exp(m_acc, b, cin, n);
        end else begin
            send_beat(a, bit'($urandom_range(0, 1)), acc, n);
            // acc_mode on the B beat must be ignored.
            send_beat(b, cin, bit'($urandom_range(0, 1)), n);
            push_exp(a, b, cin, n);
        end
    endtask

    task automatic wait_result();
        int waited = 0;
        while (!res_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) chk("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic finish_op(input int hold);
        wait_result();
        repeat (hold) @(negedge clk);
        chk("res_valid_held", 32'(res_valid), 32'd1);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        in_cin   = 1'b0;
        in_valid = 1'b0;
        acc_mode = 1'b0;
        res_ack  = 1'b0;
        model_reset();

        #3;
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operations
        do_op(1'b0, 6'h2A, 6'h15, 1'b1);   // 0x40
        finish_op(3);
        do_op(1'b0, 6'h3F, 6'h3F, 1'b1);   // 0x7F
        finish_op(1);
        do_op(1'b0, 6'h2A, 6'h15, 1'b0);   // 0x3F
        finish_op(0);

        // Accumulate: one beat, straight to EVAL
        chk("chain_acc_ok", 32'(m_acc_ok), 32'd1);
        send_beat(6'h01, 1'b0, 1'b1, n);
        push_exp(m_acc, 6'h01, 1'b0, n);
        chk("chain_busy", 32'(busy), 32'd1);
        chk("chain_no_wait_b", 32'(in_ready), 32'd0);
        chk("chain_op_a", 32'(op_a), 32'h3F);
        chk("chain_op_b", 32'(op_b), 32'h01);

        // Backpressure in HOLD
        wait_result();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 6'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res_data", 32'(res_data), 32'h40);
        end
        chk("bp_op_b", 32'(op_b), 32'h01);
        res_ack  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        res_ack = 1'b0;
        chk("ack_in_ready", 32'(in_ready), 32'd1);
        chk("ack_res_valid", 32'(res_valid), 32'd0);

        // Clear in WAIT_B, with a beat dropped in the same cycle
        send_beat(6'h10, 1'b0, 1'b0, n);
        chk("wb_busy", 32'(busy), 32'd1);
        chk("wb_op_a", 32'(op_a), 32'h10);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 6'h33;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        m_acc_ok = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_op_a", 32'(op_a), 32'd0);
        chk("clr_op_b", 32'(op_b), 32'd0);
        chk("clr_res_data", 32'(res_data), 32'h40);
        chk("clr_op_count", 32'(op_count), 32'd4);
        send_beat(6'h05, 1'b0, 1'b1, n);
        chk("clr_acc_wait_b", 32'({busy, in_ready}), 32'b11);
        chk("clr_acc_op_a", 32'(op_a), 32'h05);
        send_beat(6'h07, 1'b0, 1'b0, n);
        push_exp(6'h05, 6'h07, 1'b0, n);   // 0x0C
        finish_op(0);

        // Asynchronous reset during HOLD
        do_op(1'b0, 6'h01, 6'h02, 1'b0);
        wait_result();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_res_data", 32'(res_data), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        chk("arst_ops", 32'({op_a, op_b, op_cin}), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized operations through counter saturation
        for (int i = 0; i < 260; i++) begin
            do_op(bit'($urandom_range(0, 1)), 6'($urandom), 6'($urandom),
                  bit'($urandom_range(0, 1)));
            finish_op($urandom_range(0, 2));
        end
        chk("sat_op_count", 32'(op_count), 32'hFF);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bk_operand_sequencer
